// File: rtl/fifo_pkg.sv
// Shared types and default parameters for the FIFO drain controller.
package fifo_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_FILL_TIMEOUT = 16;
  localparam int CNT_W            = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    READ  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// FIFO read side plus downstream valid/ready stream of the drain controller.
// The master modport is the controller; the slave modport is the FIFO/sink side.
interface fifo_drain_ctrl_if #(
  parameter int DATA_W = fifo_pkg::DEF_DATA_W
);
  import fifo_pkg::*;

  logic              f_empty;
  logic              f_almost_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              enable_rd;
  logic              flush;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [CNT_W-1:0]  rd_count;

  modport master (
    input  f_empty, f_almost_empty, fifo_data, flush, m_ready,
    output enable_rd, m_data, m_valid, rd_count
  );

  modport slave (
    output f_empty, f_almost_empty, fifo_data, flush, m_ready,
    input  enable_rd, m_data, m_valid, rd_count
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer: head is the oldest word, tail the newer one.
// The caller guarantees no push into a full buffer and no pop from an empty one.
module fifo_skid_buf import fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;

  // Next-state of the two entries; a simultaneous push and pop keeps the count.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) head_d = data_i;
        else               tail_d = data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = data_i;
        end else begin
          head_d = data_i;
        end
      end
      default: ;
    endcase
  end

  // Entry and occupancy registers, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign data_o      = head_q;
  assign occupancy_o = occ_q;
  assign valid_o     = (occ_q != 2'd0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a FIFO with 1-cycle read latency into a valid/ready stream.
// Waits in ARMED for the FIFO to fill (or flush/timeout) before reading.
module fifo_drain_ctrl import fifo_pkg::*; #(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT
) (
  input logic                rd_clk,
  input logic                reset,
  fifo_drain_ctrl_if.master  bus
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FILL_TIMEOUT - 1);

  drain_state_t      state_q;
  logic [CNT_W-1:0]  tmoCount_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  rdCount_q, rdCount_d;

  logic [DATA_W-1:0] bufData;
  logic [1:0]        bufOccupancy;
  logic              bufValid;
  logic              pop;
  logic [2:0]        levelAfterPop;
  logic              enableRd;

  // Read strobe only when the buffer is guaranteed a free slot for the returning word.
  always_comb begin
    pop           = bufValid & bus.m_ready & ~reset;
    levelAfterPop = {1'b0, bufOccupancy} + {2'b00, inflight_q} - {2'b00, pop};
    enableRd      = (state_q == READ) & ~bus.f_empty & (levelAfterPop < 3'd2) & ~reset;
    rdCount_d     = rdCount_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Drain FSM with fill timeout; also tracks the word returning from the FIFO.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tmoCount_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= enableRd;
      case (state_q)
        IDLE: begin
          if (!bus.f_empty) begin
            state_q    <= ARMED;
            tmoCount_q <= '0;
          end
        end
        ARMED: begin
          if (!bus.f_almost_empty || bus.flush || (tmoCount_q == TMO_LAST)) state_q <= READ;
          else tmoCount_q <= tmoCount_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        READ: begin
          if (bus.f_empty && !inflight_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Delivered-word counter, wraps naturally at 16 bits.
  always_ff @(posedge rd_clk) begin
    if (reset)    rdCount_q <= '0;
    else if (pop) rdCount_q <= rdCount_d;
  end

  fifo_skid_buf #(.DATA_W(DATA_W)) skidBuf (
    .clk_i       (rd_clk),
    .rst_i       (reset),
    .push_i      (inflight_q),
    .pop_i       (pop),
    .data_i      (bus.fifo_data),
    .data_o      (bufData),
    .occupancy_o (bufOccupancy),
    .valid_o     (bufValid)
  );

  assign bus.enable_rd = enableRd;
  assign bus.m_valid   = bufValid & ~reset;
  assign bus.m_data    = bufData;
  assign bus.rd_count  = rdCount_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl: a behavioural FIFO with 1-cycle read
// latency feeds the DUT, a monitor logs transfers and protocol violations.
module tb_fifo_drain_ctrl;
  import fifo_pkg::*;

  localparam int DATA_W       = 8;
  localparam int FILL_TIMEOUT = 16;
  localparam int HALF         = 5;

  logic rd_clk = 1'b0;
  logic reset;

  fifo_drain_ctrl_if #(.DATA_W(DATA_W)) bus ();

  fifo_drain_ctrl #(.DATA_W(DATA_W), .FILL_TIMEOUT(FILL_TIMEOUT)) dut (
    .rd_clk (rd_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #HALF rd_clk = ~rd_clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  always @(posedge rd_clk) cyc <= cyc + 1;

  // Behavioural FIFO: words appended by the stimulus, read data valid one cycle after enable_rd.
  logic [DATA_W-1:0] pushData [0:255];
  int pushWr = 0;
  int rdPtr  = 0;
  int dropTo = 0;

  assign bus.f_empty        = (pushWr == rdPtr);
  assign bus.f_almost_empty = ((pushWr - rdPtr) <= 2);

  always @(posedge rd_clk) begin
    if (reset) rdPtr <= dropTo;
    else if (bus.enable_rd) begin
      bus.fifo_data <= pushData[rdPtr];
      rdPtr         <= rdPtr + 1;
    end
  end

  // Downstream ready driver: fixed level or the 1,0,0,1 stall pattern.
  logic       readyLevel  = 1'b1;
  logic       toggleReady = 1'b0;
  logic [3:0] readyPat    = 4'b1001;
  int         phase       = 0;

  always begin
    @(negedge rd_clk);
    #1;
    if (toggleReady) begin
      bus.m_ready = readyPat[phase];
      phase = (phase + 1) % 4;
    end else begin
      bus.m_ready = readyLevel;
      phase = 0;
    end
  end

  // Monitor sampled mid-cycle: transfer log, edge timestamps, invariant violations.
  logic [DATA_W-1:0] gotData [$];
  int gotCyc [$];
  int armedCycs [$];
  int enRiseCycs [$];
  int valRiseCycs [$];
  int underflowErr = 0;
  int occErr       = 0;
  int stableErr    = 0;
  logic prevEn = 1'b0, prevVal = 1'b0, stalledPrev = 1'b0;
  logic [DATA_W-1:0] prevData = '0;
  drain_state_t prevState = IDLE;

  always begin
    @(negedge rd_clk);
    #2;
    if (reset) begin
      prevEn = 1'b0; prevVal = 1'b0; stalledPrev = 1'b0; prevState = IDLE;
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        gotData.push_back(bus.m_data);
        gotCyc.push_back(cyc);
      end
      if (bus.enable_rd && bus.f_empty) underflowErr++;
      if (dut.bufOccupancy > 2'd2) occErr++;
      if (stalledPrev && (bus.m_valid !== 1'b1 || bus.m_data !== prevData)) stableErr++;
      if (bus.enable_rd && !prevEn) enRiseCycs.push_back(cyc);
      if (bus.m_valid && !prevVal) valRiseCycs.push_back(cyc);
      if (dut.state_q == ARMED && prevState != ARMED) armedCycs.push_back(cyc);
      stalledPrev = bus.m_valid && !bus.m_ready;
      prevData    = bus.m_data;
      prevEn      = bus.enable_rd;
      prevVal     = bus.m_valid;
      prevState   = dut.state_q;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge rd_clk);
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] words [8], input int n);
    for (int i = 0; i < n; i++) begin
      pushData[pushWr] = words[i];
      pushWr++;
    end
  endtask

  task automatic applyReset();
    reset  = 1'b1;
    dropTo = pushWr;
    waitCycles(2);
    reset  = 1'b0;
  endtask

  task automatic waitForCount(input string tag, input int target, input int budget);
    int k = 0;
    while (gotData.size() < target && k < budget) begin
      @(negedge rd_clk);
      k++;
    end
    checkOutput(tag, 32'(gotData.size()), 32'(target));
  endtask

  function automatic logic [31:0] gotAt(input int idx);
    if (idx < gotData.size()) return 32'(gotData[idx]);
    return 'x;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DATA_W-1:0] w [8];
    int base, eb, ab, vb, ub, ob, sb;

    reset    = 1'b1;
    bus.flush = 1'b0;
    waitCycles(2);
    checkOutput("rst_hold_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("rst_hold_enable", 32'(bus.enable_rd), 32'd0);
    reset = 1'b0;
    waitCycles(1);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("rst_count", 32'(bus.rd_count), 32'd0);
    checkOutput("rst_data", 32'(bus.m_data), 32'd0);
    checkOutput("rst_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("rst_enable", 32'(bus.enable_rd), 32'd0);

    // Fill then drain at full rate.
    $display("[TB] fill-then-drain");
    base = gotData.size(); eb = enRiseCycs.size(); vb = valRiseCycs.size();
    w = '{8'h0A, 8'h10, 8'h41, 8'h13, 8'hAA, 8'hAA, 8'hBB, 8'hFF};
    applyStimulus(w, 8);
    waitForCount("fill_count", base + 8, 80);
    waitCycles(4);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("fill_data%0d", i), gotAt(base + i), 32'(w[i]));
    checkOutput("fill_latency", 32'(valRiseCycs[vb] - enRiseCycs[eb]), 32'd2);
    checkOutput("fill_throughput", 32'(gotCyc[base + 7] - gotCyc[base]), 32'd7);
    checkOutput("fill_rd_count", 32'(bus.rd_count), 32'd8);
    checkOutput("fill_state", 32'(dut.state_q), 32'(IDLE));

    // Single word, no flush: wait out the fill timeout.
    $display("[TB] timeout");
    applyReset();
    base = gotData.size(); eb = enRiseCycs.size(); ab = armedCycs.size();
    w[0] = 8'h07;
    applyStimulus(w, 1);
    waitForCount("tmo_count", base + 1, 60);
    waitCycles(3);
    checkOutput("tmo_wait", 32'(enRiseCycs[eb] - armedCycs[ab]), 32'd16);
    checkOutput("tmo_data", gotAt(base), 32'h07);
    checkOutput("tmo_rd_count", 32'(bus.rd_count), 32'd1);
    checkOutput("tmo_state", 32'(dut.state_q), 32'(IDLE));

    // Flush skips the fill wait.
    $display("[TB] flush");
    applyReset();
    base = gotData.size(); eb = enRiseCycs.size(); ab = armedCycs.size();
    bus.flush = 1'b1;
    w[0] = 8'h21; w[1] = 8'h22;
    applyStimulus(w, 2);
    waitForCount("flush_count", base + 2, 40);
    bus.flush = 1'b0;
    checkOutput("flush_wait", 32'(enRiseCycs[eb] - armedCycs[ab]), 32'd1);
    checkOutput("flush_data0", gotAt(base), 32'h21);
    checkOutput("flush_data1", gotAt(base + 1), 32'h22);

    // Backpressure with ready toggling 1,0,0,1.
    $display("[TB] backpressure");
    applyReset();
    base = gotData.size(); ub = underflowErr; ob = occErr; sb = stableErr;
    toggleReady = 1'b1;
    w = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};
    applyStimulus(w, 8);
    waitForCount("bp_count", base + 8, 200);
    waitCycles(4);
    toggleReady = 1'b0;
    for (int i = 0; i < 8; i++) checkOutput($sformatf("bp_data%0d", i), gotAt(base + i), 32'(w[i]));
    checkOutput("bp_extra", 32'(gotData.size()), 32'(base + 8));
    checkOutput("bp_rd_count", 32'(bus.rd_count), 32'd8);
    checkOutput("bp_underflow", 32'(underflowErr - ub), 32'd0);
    checkOutput("bp_occupancy", 32'(occErr - ob), 32'd0);
    checkOutput("bp_stable", 32'(stableErr - sb), 32'd0);

    // Reset in the middle of a burst discards buffered words.
    $display("[TB] mid-burst reset");
    applyReset();
    readyLevel = 1'b1;
    base = gotData.size();
    w = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
    applyStimulus(w, 8);
    waitForCount("mid_pre_count", base + 3, 60);
    reset  = 1'b1;
    dropTo = pushWr;
    #3;
    checkOutput("mid_hold_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("mid_hold_enable", 32'(bus.enable_rd), 32'd0);
    @(negedge rd_clk);
    reset = 1'b0;
    checkOutput("mid_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("mid_enable", 32'(bus.enable_rd), 32'd0);
    checkOutput("mid_rd_count", 32'(bus.rd_count), 32'd0);
    checkOutput("mid_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("mid_data", 32'(bus.m_data), 32'd0);
    waitCycles(5);
    checkOutput("mid_no_stale", 32'(gotData.size()), 32'(base + 3));

    // Counter wrap from 16'hFFFF.
    $display("[TB] wrap");
    force dut.rdCount_q = 16'hFFFF;
    #1;
    release dut.rdCount_q;
    checkOutput("wrap_preload", 32'(bus.rd_count), 32'h0000FFFF);
    base = gotData.size();
    bus.flush = 1'b1;
    w[0] = 8'h99;
    applyStimulus(w, 1);
    waitForCount("wrap_xfer", base + 1, 40);
    bus.flush = 1'b0;
    waitCycles(2);
    checkOutput("wrap_count", 32'(bus.rd_count), 32'd0);
    checkOutput("wrap_data", gotAt(base), 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
